// File: rtl/tl_pkg.sv
// Shared TileLink definitions: A-channel opcodes and opcode helpers.
package tl_pkg;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        ARITHMETIC_DATA  = 3'd2,
        LOGICAL_DATA     = 3'd3,
        GET              = 3'd4,
        INTENT           = 3'd5,
        ACQUIRE_BLOCK    = 3'd6,
        ACQUIRE_PERM     = 3'd7
    } tl_a_op_e;

    // Data-carrying A opcodes occupy 0..3, so bit 2 clear means a data payload.
    function automatic logic has_data(input logic [2:0] opcode);
        return !opcode[2];
    endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Round-robin request picker: grants the first requester at or after ptr, wrapping.
// Purely combinational so callers decide when the pointer advances.
// Ports:
//   req      in   N      request vector
//   ptr      in   IdxW   highest-priority index this cycle
//   gnt_c    out  N      one-hot grant (zero when no request)
//   idx_c    out  IdxW   index of the granted requester
//   valid_c  out  1      any request present
module tl_rr_arbiter #(
    parameter  int unsigned N    = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt_c,
    output logic [IdxW-1:0] idx_c,
    output logic            valid_c
);

    int unsigned       pos;
    logic [IdxW-1:0]   cand;

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt_c   = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        pos     = 0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = IdxW'(pos);
            if (!valid_c && req[cand]) begin
                valid_c     = 1'b1;
                idx_c       = cand;
                gnt_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_a_burst_arbiter.sv
// Round-robin arbiter sharing one TileLink A channel between NumHosts requesters.
// A multi-beat burst keeps the grant until its last beat; the outgoing source is
// widened with the host index, and D responses are steered back by those bits.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   host_a_valid/ready                per-host A handshake
//   host_a_opcode/size/source/address/data   per-host A payload, flattened
//   dev_a_valid/ready, dev_a_*        shared A channel toward the device
//   dev_d_valid/ready, dev_d_source   D response from the device
//   host_d_valid/ready                per-host D handshake
module tl_a_burst_arbiter
    import tl_pkg::*;
#(
    parameter  int unsigned NumHosts    = 4,
    parameter  int unsigned DataWidth   = 64,
    parameter  int unsigned AddrWidth   = 56,
    parameter  int unsigned SourceWidth = 4,
    parameter  int unsigned MaxSize     = 6,
    localparam int unsigned IdxW        = $clog2(NumHosts),
    localparam int unsigned SizeW       = $clog2(MaxSize + 1),
    localparam int unsigned OutSrcW     = SourceWidth + IdxW
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumHosts-1:0]             host_a_valid,
    output logic [NumHosts-1:0]             host_a_ready,
    input  logic [NumHosts*3-1:0]           host_a_opcode,
    input  logic [NumHosts*SizeW-1:0]       host_a_size,
    input  logic [NumHosts*SourceWidth-1:0] host_a_source,
    input  logic [NumHosts*AddrWidth-1:0]   host_a_address,
    input  logic [NumHosts*DataWidth-1:0]   host_a_data,
    output logic                            dev_a_valid,
    input  logic                            dev_a_ready,
    output logic [2:0]                      dev_a_opcode,
    output logic [SizeW-1:0]                dev_a_size,
    output logic [OutSrcW-1:0]              dev_a_source,
    output logic [AddrWidth-1:0]            dev_a_address,
    output logic [DataWidth-1:0]            dev_a_data,
    input  logic                            dev_d_valid,
    output logic                            dev_d_ready,
    input  logic [OutSrcW-1:0]              dev_d_source,
    output logic [NumHosts-1:0]             host_d_valid,
    input  logic [NumHosts-1:0]             host_d_ready
);

    localparam int unsigned BusLg = $clog2(DataWidth / 8);
    localparam int unsigned BeatW = MaxSize + 1 - BusLg;

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    // Per-host views of the flattened payload buses.
    logic [2:0]             op_arr   [NumHosts];
    logic [SizeW-1:0]       size_arr [NumHosts];
    logic [SourceWidth-1:0] src_arr  [NumHosts];
    logic [AddrWidth-1:0]   addr_arr [NumHosts];
    logic [DataWidth-1:0]   data_arr [NumHosts];

    for (genvar h = 0; h < NumHosts; h++) begin : g_unpack
        assign op_arr[h]   = host_a_opcode[h*3 +: 3];
        assign size_arr[h] = host_a_size[h*SizeW +: SizeW];
        assign src_arr[h]  = host_a_source[h*SourceWidth +: SourceWidth];
        assign addr_arr[h] = host_a_address[h*AddrWidth +: AddrWidth];
        assign data_arr[h] = host_a_data[h*DataWidth +: DataWidth];
    end

    state_e              state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     lock_idx_q, lock_idx_d;
    logic                hold_q, hold_d;
    logic [BeatW-1:0]    beats_left_q, beats_left_d;

    logic [NumHosts-1:0] arb_gnt;
    logic [IdxW-1:0]     arb_idx;
    logic                arb_any;

    logic                locked;
    logic [IdxW-1:0]     sel_idx;
    logic [NumHosts-1:0] sel_onehot;
    logic                sel_valid;
    logic                a_fire;
    logic [BeatW-1:0]    req_beats;

    tl_rr_arbiter #(.N(NumHosts)) u_rr (
        .req     (host_a_valid),
        .ptr     (rr_ptr_q),
        .gnt_c   (arb_gnt),
        .idx_c   (arb_idx),
        .valid_c (arb_any)
    );

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
        return (32'(i) == NumHosts - 1) ? '0 : i + IdxW'(1);
    endfunction

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            hold_q       <= 1'b0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_idx_q   <= lock_idx_d;
            hold_q       <= hold_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Grant selection, A mux and next-state logic.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_idx_d    = lock_idx_q;
        hold_d        = hold_q;
        beats_left_d  = beats_left_q;
        host_a_ready  = '0;
        req_beats     = BeatW'(1);

        // A burst, or a beat offered but not yet taken, pins the grant.
        locked     = (state_q == ST_BURST) || hold_q;
        sel_idx    = locked ? lock_idx_q : arb_idx;
        sel_onehot = locked ? (NumHosts'(1) << lock_idx_q) : arb_gnt;
        sel_valid  = (locked ? host_a_valid[lock_idx_q] : arb_any) && !rst_i;
        a_fire     = sel_valid && dev_a_ready;

        dev_a_valid   = sel_valid;
        dev_a_opcode  = op_arr[sel_idx];
        dev_a_size    = size_arr[sel_idx];
        dev_a_source  = {sel_idx, src_arr[sel_idx]};
        dev_a_address = addr_arr[sel_idx];
        dev_a_data    = data_arr[sel_idx];
        if (a_fire) begin
            host_a_ready = sel_onehot;
        end

        if (has_data(op_arr[sel_idx]) && (size_arr[sel_idx] > SizeW'(BusLg))) begin
            req_beats = BeatW'(1) << (size_arr[sel_idx] - SizeW'(BusLg));
        end

        case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    hold_d = 1'b0;
                    if (req_beats != BeatW'(1)) begin
                        state_d      = ST_BURST;
                        lock_idx_d   = sel_idx;
                        beats_left_d = req_beats - BeatW'(1);
                    end else begin
                        rr_ptr_d = next_idx(sel_idx);
                    end
                end else if (sel_valid) begin
                    hold_d     = 1'b1;
                    lock_idx_d = sel_idx;
                end
            end
            ST_BURST: begin
                if (a_fire) begin
                    beats_left_d = beats_left_q - BeatW'(1);
                    if (beats_left_q == BeatW'(1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_idx(lock_idx_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // D demux: the top IdxW source bits name the host.
    logic [IdxW-1:0] d_idx;
    logic            d_idx_ok;
    logic            unused_d_src;

    assign d_idx        = dev_d_source[OutSrcW-1 -: IdxW];
    assign unused_d_src = ^dev_d_source[SourceWidth-1:0];

    if ((32'd1 << IdxW) == NumHosts) begin : g_pow2_idx
        assign d_idx_ok = 1'b1;
    end else begin : g_npow2_idx
        assign d_idx_ok = (32'(d_idx) < NumHosts);
    end

    assign host_d_valid = (dev_d_valid && d_idx_ok && !rst_i) ? (NumHosts'(1) << d_idx) : '0;
    assign dev_d_ready  = d_idx_ok && !rst_i && host_d_ready[d_idx];

    a_d_idx_range: assert property (@(posedge clk_i) disable iff (rst_i) dev_d_valid |-> d_idx_ok);

endmodule

// File: tb/tb_tl_a_burst_arbiter.sv
// Self-checking bench for tl_a_burst_arbiter: host beat queues feed the A side,
// an expected-beat queue is compared on every device fire, and a vector table
// exercises the D demux.
module tb_tl_a_burst_arbiter;
    import tl_pkg::*;

    localparam int unsigned NumHosts    = 4;
    localparam int unsigned DataWidth   = 64;
    localparam int unsigned AddrWidth   = 56;
    localparam int unsigned SourceWidth = 4;
    localparam int unsigned MaxSize     = 6;
    localparam int unsigned IdxW        = 2;
    localparam int unsigned SizeW       = 3;
    localparam int unsigned OutSrcW     = SourceWidth + IdxW;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic [NumHosts-1:0]             host_a_valid, host_a_ready;
    logic [NumHosts*3-1:0]           host_a_opcode;
    logic [NumHosts*SizeW-1:0]       host_a_size;
    logic [NumHosts*SourceWidth-1:0] host_a_source;
    logic [NumHosts*AddrWidth-1:0]   host_a_address;
    logic [NumHosts*DataWidth-1:0]   host_a_data;
    logic                            dev_a_valid, dev_a_ready;
    logic [2:0]                      dev_a_opcode;
    logic [SizeW-1:0]                dev_a_size;
    logic [OutSrcW-1:0]              dev_a_source;
    logic [AddrWidth-1:0]            dev_a_address;
    logic [DataWidth-1:0]            dev_a_data;
    logic                            dev_d_valid, dev_d_ready;
    logic [OutSrcW-1:0]              dev_d_source;
    logic [NumHosts-1:0]             host_d_valid, host_d_ready;

    logic [2:0]             h_op   [NumHosts];
    logic [SizeW-1:0]       h_size [NumHosts];
    logic [SourceWidth-1:0] h_src  [NumHosts];
    logic [AddrWidth-1:0]   h_addr [NumHosts];
    logic [DataWidth-1:0]   h_data [NumHosts];

    for (genvar g = 0; g < NumHosts; g++) begin : g_pack
        assign host_a_opcode[g*3 +: 3]                   = h_op[g];
        assign host_a_size[g*SizeW +: SizeW]             = h_size[g];
        assign host_a_source[g*SourceWidth +: SourceWidth] = h_src[g];
        assign host_a_address[g*AddrWidth +: AddrWidth]  = h_addr[g];
        assign host_a_data[g*DataWidth +: DataWidth]     = h_data[g];
    end

    tl_a_burst_arbiter #(
        .NumHosts(NumHosts), .DataWidth(DataWidth), .AddrWidth(AddrWidth),
        .SourceWidth(SourceWidth), .MaxSize(MaxSize)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_a_valid(host_a_valid), .host_a_ready(host_a_ready),
        .host_a_opcode(host_a_opcode), .host_a_size(host_a_size),
        .host_a_source(host_a_source), .host_a_address(host_a_address),
        .host_a_data(host_a_data),
        .dev_a_valid(dev_a_valid), .dev_a_ready(dev_a_ready),
        .dev_a_opcode(dev_a_opcode), .dev_a_size(dev_a_size),
        .dev_a_source(dev_a_source), .dev_a_address(dev_a_address),
        .dev_a_data(dev_a_data),
        .dev_d_valid(dev_d_valid), .dev_d_ready(dev_d_ready),
        .dev_d_source(dev_d_source),
        .host_d_valid(host_d_valid), .host_d_ready(host_d_ready)
    );

    typedef struct {
        logic [2:0]             op;
        logic [SizeW-1:0]       size;
        logic [SourceWidth-1:0] src;
        logic [AddrWidth-1:0]   addr;
        logic [DataWidth-1:0]   data;
    } beat_t;

    typedef struct {
        int    host;
        beat_t b;
    } exp_t;

    typedef struct {
        logic                v;
        logic [OutSrcW-1:0]  src;
        logic [NumHosts-1:0] hr;
        logic [NumHosts-1:0] exp_hv;
        logic                exp_r;
    } dvec_t;

    beat_t               hq [NumHosts][$];
    exp_t                sb [$];
    logic [NumHosts-1:0] pause;
    logic [NumHosts-1:0] took;
    logic                rst_req, ready_req;
    int                  n_checks = 0;
    int                  n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int h, input logic [2:0] op, input int size,
                                 input int src, input logic [AddrWidth-1:0] addr, input int k);
        beat_t b;
        b.op   = op;
        b.size = SizeW'(size);
        b.src  = SourceWidth'(src);
        b.addr = addr;
        b.data = {8'(h), 8'(src), 48'(k)};
        return b;
    endfunction

    // Queue a request of n beats on host h.
    task automatic req(input int h, input logic [2:0] op, input int size, input int src,
                       input logic [AddrWidth-1:0] addr, input int n);
        for (int k = 0; k < n; k++) hq[h].push_back(mk(h, op, size, src, addr, k));
    endtask

    // Record the beats the device is expected to see, in order.
    task automatic expect_req(input int h, input logic [2:0] op, input int size, input int src,
                              input logic [AddrWidth-1:0] addr, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.host = h;
            e.b    = mk(h, op, size, src, addr, k);
            sb.push_back(e);
        end
    endtask

    function automatic bit pending();
        for (int h = 0; h < NumHosts; h++)
            if (hq[h].size() > int'(took[h])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int h = 0; h < NumHosts; h++) begin
            if (hq[h].size() > 0 && !pause[h]) begin
                host_a_valid[h] = 1'b1;
                h_op[h]   = hq[h][0].op;
                h_size[h] = hq[h][0].size;
                h_src[h]  = hq[h][0].src;
                h_addr[h] = hq[h][0].addr;
                h_data[h] = hq[h][0].data;
            end else begin
                host_a_valid[h] = 1'b0;
                h_op[h]   = '0;
                h_size[h] = '0;
                h_src[h]  = '0;
                h_addr[h] = '0;
                h_data[h] = '0;
            end
        end
    endtask

    // One clock: retire last cycle's accepted beats, drive at negedge, observe 1ns later.
    task automatic step();
        exp_t e;
        @(posedge clk_i);
        for (int h = 0; h < NumHosts; h++) if (took[h]) void'(hq[h].pop_front());
        @(negedge clk_i);
        rst_i       = rst_req;
        dev_a_ready = ready_req;
        drive();
        #1;
        took = host_a_valid & host_a_ready;
        if (dev_a_valid && dev_a_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got source 0x%0h data 0x%0h, want no beat",
                         dev_a_source, dev_a_data);
            end else begin
                e = sb.pop_front();
                check("a_source",  dev_a_source,  {IdxW'(e.host), e.b.src});
                check("a_data",    dev_a_data,    e.b.data);
                check("a_address", dev_a_address, e.b.addr);
                check("a_opcode",  dev_a_opcode,  e.b.op);
                check("a_size",    dev_a_size,    e.b.size);
                check("a_ready",   host_a_ready,  NumHosts'(1) << e.host);
            end
        end
    endtask

    task automatic run(input string name, input int max_cyc, input int exp_cyc);
        int c;
        c = 0;
        while ((sb.size() > 0 || pending()) && c < max_cyc) begin
            step();
            c++;
        end
        check({name, "_cycles"}, 128'(c), 128'(exp_cyc));
        if (sb.size() > 0 || pending()) begin
            sb.delete();
            for (int h = 0; h < NumHosts; h++) hq[h].delete();
        end
    endtask

    dvec_t dv [6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_i = 1'b1; rst_req = 1'b1; ready_req = 1'b1; dev_a_ready = 1'b1;
        pause = '0; took = '0; host_a_valid = '0;
        dev_d_valid = 1'b0; dev_d_source = '0; host_d_ready = '0;
        drive();

        // Reset: all handshake outputs held low even with requests present.
        req(2, GET, 6, 1, 56'h1000, 1);
        dev_d_valid = 1'b1; dev_d_source = {2'd3, 4'h5}; host_d_ready = '1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_dev_a_valid",  dev_a_valid,  1'b0);
            check("rst_host_a_ready", host_a_ready, 4'b0);
            check("rst_host_d_valid", host_d_valid, 4'b0);
            check("rst_dev_d_ready",  dev_d_ready,  1'b0);
        end
        dev_d_valid = 1'b0; host_d_ready = '0;
        rst_req = 1'b0;
        expect_req(2, GET, 6, 1, 56'h1000, 1);
        run("post_reset", 10, 1);                          // rr_ptr -> 3

        // Single Get of 64 bytes on a 64-bit bus is one beat.
        req(0, GET, 6, 7, 56'h2000, 1);
        expect_req(0, GET, 6, 7, 56'h2000, 1);
        run("single_get", 10, 1);                          // rr_ptr -> 1
        req(0, GET, 6, 2, 56'h2100, 1);
        req(1, GET, 3, 3, 56'h2200, 1);
        expect_req(1, GET, 3, 3, 56'h2200, 1);
        expect_req(0, GET, 6, 2, 56'h2100, 1);
        run("ptr_after_host0", 10, 2);                     // rr_ptr -> 1

        // Two 4-beat PutFull bursts must not interleave.
        req(3, GET, 3, 0, 56'h3000, 1);
        expect_req(3, GET, 3, 0, 56'h3000, 1);
        run("align_ptr0", 10, 1);                          // rr_ptr -> 0
        req(0, PUT_FULL_DATA, 5, 4, 56'h4000, 4);
        req(1, PUT_FULL_DATA, 5, 9, 56'h4100, 4);
        expect_req(0, PUT_FULL_DATA, 5, 4, 56'h4000, 4);
        expect_req(1, PUT_FULL_DATA, 5, 9, 56'h4100, 4);
        run("bursts", 20, 8);                              // rr_ptr -> 2

        // Fairness: grants 0,1,2,3,0 back to back.
        req(3, GET, 3, 0, 56'h3000, 1);
        expect_req(3, GET, 3, 0, 56'h3000, 1);
        run("align_ptr0b", 10, 1);                         // rr_ptr -> 0
        req(0, GET, 3, 10, 56'h5000, 1);
        req(0, GET, 3, 11, 56'h5008, 1);
        req(1, GET, 3, 1, 56'h5100, 1);
        req(2, GET, 3, 2, 56'h5200, 1);
        req(3, GET, 3, 3, 56'h5300, 1);
        expect_req(0, GET, 3, 10, 56'h5000, 1);
        expect_req(1, GET, 3, 1, 56'h5100, 1);
        expect_req(2, GET, 3, 2, 56'h5200, 1);
        expect_req(3, GET, 3, 3, 56'h5300, 1);
        expect_req(0, GET, 3, 11, 56'h5008, 1);
        run("fairness", 20, 5);                            // rr_ptr -> 1

        // Host 2 stalls mid-burst; host 3 must wait for the 4th beat.
        req(2, PUT_FULL_DATA, 5, 6, 56'h6000, 4);
        req(3, GET, 4, 1, 56'h6100, 1);
        expect_req(2, PUT_FULL_DATA, 5, 6, 56'h6000, 4);
        expect_req(3, GET, 4, 1, 56'h6100, 1);
        c = 0;
        while (sb.size() > 3 && c < 10) begin
            step();
            c++;
        end
        check("stall_first_beats", 128'(c), 128'd2);
        pause[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_dev_a_valid", dev_a_valid, 1'b0);
            check("stall_host3_ready", host_a_ready[3], 1'b0);
        end
        pause[2] = 1'b0;
        run("stall_rest", 10, 3);                          // rr_ptr -> 0

        // Idle cycle, then the D demux vector table.
        step();
        check("idle_dev_a_valid", dev_a_valid, 1'b0);
        dv[0] = '{1'b1, {2'd3, 4'h5}, 4'b1000, 4'b1000, 1'b1};
        dv[1] = '{1'b1, {2'd3, 4'h5}, 4'b0111, 4'b1000, 1'b0};
        dv[2] = '{1'b1, {2'd0, 4'h2}, 4'b0001, 4'b0001, 1'b1};
        dv[3] = '{1'b1, {2'd1, 4'hf}, 4'b1101, 4'b0010, 1'b0};
        dv[4] = '{1'b0, {2'd2, 4'h0}, 4'b0100, 4'b0000, 1'b1};
        dv[5] = '{1'b1, {2'd2, 4'ha}, 4'b1011, 4'b0100, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            dev_d_valid  = dv[i].v;
            dev_d_source = dv[i].src;
            host_d_ready = dv[i].hr;
            #1;
            check($sformatf("d_valid_vec%0d", i), host_d_valid, dv[i].exp_hv);
            check($sformatf("d_ready_vec%0d", i), dev_d_ready,  dv[i].exp_r);
        end
        dev_d_valid = 1'b0; host_d_ready = '0;

        // Reset after the first beat of a burst: back to IDLE with rr_ptr = 0.
        req(1, GET, 3, 5, 56'h7000, 1);
        expect_req(1, GET, 3, 5, 56'h7000, 1);
        run("align_ptr2", 10, 1);                          // rr_ptr -> 2
        req(1, PUT_FULL_DATA, 5, 3, 56'h7100, 4);
        expect_req(1, PUT_FULL_DATA, 5, 3, 56'h7100, 1);
        c = 0;
        while (sb.size() > 0 && c < 10) begin
            step();
            c++;
        end
        check("rst_burst_first_beat", 128'(c), 128'd1);
        rst_req = 1'b1;
        dev_d_valid = 1'b1; dev_d_source = {2'd1, 4'h0}; host_d_ready = '1;
        step();
        check("midrst_dev_a_valid",  dev_a_valid,  1'b0);
        check("midrst_host_a_ready", host_a_ready, 4'b0);
        check("midrst_host_d_valid", host_d_valid, 4'b0);
        check("midrst_dev_d_ready",  dev_d_ready,  1'b0);
        for (int h = 0; h < NumHosts; h++) hq[h].delete();
        sb.delete();
        step();
        dev_d_valid = 1'b0; host_d_ready = '0;
        rst_req = 1'b0;
        req(0, GET, 3, 8, 56'h8000, 1);
        req(3, GET, 3, 9, 56'h8300, 1);
        expect_req(0, GET, 3, 8, 56'h8000, 1);
        expect_req(3, GET, 3, 9, 56'h8300, 1);
        run("after_midrst", 10, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
